trace_capture: RTL and testbench

Acquisition stage feeding the VGA trace renderer. It accepts an 8-bit sample stream and waits for a rising-edge trigger. It then records DEPTH decimated samples, each converted to a screen row, into a double-buffered trace RAM. The renderer reads the RAM through a registered 10-bit address / 9-bit value port. Banks swap only during vertical blanking, so a displayed frame never mixes two captures.

---
 rtl/trace_capture.sv | 159 +++++++++++++++
 tb/tb_trace_capture.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/trace_capture.sv
// trace_capture
//   Acquisition stage for the VGA trace renderer. Waits for a rising-edge
//   trigger on an 8-bit sample stream, records DEPTH decimated samples
//   (converted to screen rows) into the hidden bank of a double-buffered
//   trace RAM, then swaps banks during vertical blanking.
//
// Ports
//   clk, rst_n     system clock, asynchronous active-low reset
//   sample_valid   one-cycle qualifier per sample
//   sample         unsigned sample, 0 = bottom of screen
//   trig_level     rising-edge trigger threshold
//   decim          keep 1 of every decim+1 valid samples (latched at trigger)
//   arm            start one acquisition from IDLE
//   force_trig     trigger immediately while armed
//   auto_rearm     return to ARMED after each swap
//   vblank         renderer vertical blank; bank swap allowed while high
//   taddr          renderer read address (x), clamped to DEPTH-1
//   tvalue         registered row for taddr from the displayed bank
//   busy           acquisition in progress (held through the done cycle)
//   done           one-cycle pulse when a new bank becomes displayed
//   disp_bank      bank currently displayed
module trace_capture #(
  parameter int DEPTH = 640,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sample_valid,
  input  logic [7:0]    sample,
  input  logic [7:0]    trig_level,
  input  logic [3:0]    decim,
  input  logic          arm,
  input  logic          force_trig,
  input  logic          auto_rearm,
  input  logic          vblank,
  input  logic [AW-1:0] taddr,
  output logic [8:0]    tvalue,
  output logic          busy,
  output logic          done,
  output logic          disp_bank
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    SWAP
  } state_t;

  state_t        state;
  state_t        stateNext;
  logic [AW-1:0] waddr;
  logic [3:0]    decimCnt;
  logic [3:0]    decimLat;
  logic [7:0]    prev;

  logic [11:0]   prod;
  logic [8:0]    row;
  logic          trigHit;
  logic          fire;
  logic          wrEn;
  logic          swapNow;
  logic [AW-1:0] wrIdx;
  logic [AW-1:0] rdIdx;

  // Trace RAM, indexed [bank][x]; contents are deliberately not reset.
  logic [8:0]    mem [2][DEPTH];

  // Screen row: 479 - floor(sample * 15 / 8), 0 -> 479, 255 -> 1.
  always_comb begin
    prod = 12'(sample) * 12'd15;
    row  = 9'(12'd479 - (prod >> 3));
  end

  always_comb begin
    trigHit = sample_valid && (prev < trig_level) && (sample >= trig_level);
    fire    = force_trig || trigHit;
    rdIdx   = (taddr > LAST) ? LAST : taddr;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (arm) stateNext = ARMED;
      ARMED:   if (fire) stateNext = CAPTURE;
      CAPTURE: if (sample_valid && (decimCnt == '0) && (waddr == LAST)) stateNext = SWAP;
      SWAP:    if (vblank) stateNext = (auto_rearm || arm) ? ARMED : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Output / strobe logic
  always_comb begin
    wrEn    = 1'b0;
    swapNow = 1'b0;
    wrIdx   = waddr;
    unique case (state)
      ARMED: begin
        wrEn  = fire;
        wrIdx = '0;
      end
      CAPTURE: wrEn    = sample_valid && (decimCnt == '0);
      SWAP:    swapNow = vblank;
      default: ;
    endcase
  end

  // Capture writes always target the hidden bank.
  always_ff @(posedge clk) begin
    if (wrEn) mem[~disp_bank][wrIdx] <= row;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr     <= '0;
      decimCnt  <= '0;
      decimLat  <= '0;
      prev      <= '1;
      disp_bank <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      tvalue    <= '0;
    end else begin
      if (sample_valid) prev <= sample;

      // Read uses the pre-swap bank on the swap edge itself.
      tvalue <= mem[disp_bank][rdIdx];

      done <= swapNow;
      if (swapNow) disp_bank <= ~disp_bank;

      // Held high through the done cycle so busy falls one edge after done.
      busy <= (stateNext != IDLE) || swapNow;

      if (state == ARMED && fire) begin
        waddr    <= AW'(1);
        decimCnt <= decim;
        decimLat <= decim;
      end else if (state == CAPTURE && sample_valid) begin
        if (decimCnt == '0) begin
          waddr    <= waddr + 1'b1;
          decimCnt <= decimLat;
        end else begin
          decimCnt <= decimCnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture: expected read values and done events are
// queued when stimulus is driven and popped when the DUT responds.
module tb_trace_capture;
  localparam int DEPTH = 640;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sample_valid;
  logic [7:0]    sample;
  logic [7:0]    trig_level;
  logic [3:0]    decim;
  logic          arm;
  logic          forceTrig;
  logic          auto_rearm;
  logic          vblank;
  logic [AW-1:0] taddr;
  logic [8:0]    tvalue;
  logic          busy;
  logic          done;
  logic          disp_bank;

  always #10 clk = ~clk;

  trace_capture #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample(sample),
    .trig_level(trig_level), .decim(decim), .arm(arm), .force_trig(forceTrig),
    .auto_rearm(auto_rearm), .vblank(vblank), .taddr(taddr), .tvalue(tvalue),
    .busy(busy), .done(done), .disp_bank(disp_bank)
  );

  int compared   = 0;
  int mismatched = 0;
  int streamK    = 0;
  int expQ[$];
  int doneKQ[$];
  int doneBankQ[$];
  int expBank[DEPTH];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int rowOf(input int s);
    return 479 - (((s % 256) * 15) / 8);
  endfunction

  task automatic readAt(input string tag, input int addr, input int expRow);
    taddr = AW'(addr);
    expQ.push_back(expRow);
    tick();
    check(tag, 32'(tvalue), expQ.pop_front());
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < DEPTH; i++) readAt(tag, i, expBank[i]);
  endtask

  // Ramp stream k%256 with valid every cycle until done; decim input is
  // changed to decimLate mid-capture (it must have no effect).
  task automatic streamToDone(input int budget, input logic [3:0] decimLate, output int doneAt);
    doneAt = -1;
    for (int n = 0; n < budget; n++) begin
      if (streamK == 200) decim = decimLate;
      sample       = 8'(streamK % 256);
      sample_valid = 1'b1;
      tick();
      if (done) begin
        doneAt = streamK;
        break;
      end
      streamK++;
    end
    sample_valid = 1'b0;
  endtask

  initial begin
    int doneAt;
    int cnt;
    int bad;

    rst_n = 1'b0; sample_valid = 1'b0; sample = '0; trig_level = '0; decim = '0;
    arm = 1'b0; forceTrig = 1'b0; auto_rearm = 1'b0; vblank = 1'b0; taddr = '0;
    tick(); tick();
    check("rst_tvalue", 32'(tvalue), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_disp", 32'(disp_bank), 0);
    rst_n = 1'b1;
    tick();
    check("idle_busy", 32'(busy), 0);

    // Capture abandoned by reset
    trig_level = 8'd128;
    arm = 1'b1; tick(); arm = 1'b0;
    check("armed_busy", 32'(busy), 1);
    forceTrig = 1'b1; sample = 8'd10; sample_valid = 1'b1; tick(); forceTrig = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    sample_valid = 1'b0;
    check("capture_busy", 32'(busy), 1);
    rst_n = 1'b0; #1;
    check("midrst_tvalue", 32'(tvalue), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_disp", 32'(disp_bank), 0);
    tick(); rst_n = 1'b1;
    bad = 0; vblank = 1'b1; streamK = 0;
    for (int i = 0; i < 1000; i++) begin
      sample = 8'(streamK % 256); sample_valid = 1'b1;
      tick();
      streamK++;
      if (busy || done) bad++;
    end
    sample_valid = 1'b0;
    check("postrst_idle", 32'(bad), 0);
    check("postrst_disp", 32'(disp_bank), 0);

    // Rising trigger at 128, decim=0
    trig_level = 8'd128; decim = 4'd0; vblank = 1'b1;
    arm = 1'b1; tick(); arm = 1'b0;
    streamK = 0;
    streamToDone(2000, 4'd0, doneAt);
    check("d0_done_k", 32'(doneAt), 768);
    check("d0_disp", 32'(disp_bank), 1);
    check("d0_busy_at_done", 32'(busy), 1);
    tick();
    check("d0_done_pulse", 32'(done), 0);
    check("d0_busy_drop", 32'(busy), 0);
    for (int i = 0; i < DEPTH; i++) expBank[i] = rowOf(128 + i);
    readAt("d0_x0", 0, 239);
    readAt("d0_x127", 127, 1);
    readAt("d0_x128", 128, 479);
    sweep("d0_bank");
    readAt("d0_x700", 700, expBank[DEPTH-1]);

    // Decimation by 4 (decim=3), decim input changed mid-capture
    decim = 4'd3;
    arm = 1'b1; tick(); arm = 1'b0;
    streamK = 0;
    streamToDone(4000, 4'd7, doneAt);
    check("dec_done_k", 32'(doneAt), 128 + 4*DEPTH - 3);
    check("dec_disp", 32'(disp_bank), 0);
    tick();
    check("dec_done_pulse", 32'(done), 0);
    for (int i = 0; i < DEPTH; i++) expBank[i] = rowOf(128 + 4*i);
    sweep("dec_bank");

    // Swap deferred until vblank
    trig_level = 8'd64; decim = 4'd0; vblank = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
    bad = 0;
    for (int k = 0; k <= 64 + DEPTH - 1; k++) begin
      sample = 8'(k % 256); sample_valid = 1'b1;
      tick();
      if (done) bad++;
    end
    sample_valid = 1'b0;
    check("defer_no_done", 32'(bad), 0);
    for (int n = 0; n < 100; n++) readAt("defer_old", (n * 13) % DEPTH, expBank[(n * 13) % DEPTH]);
    check("defer_disp_old", 32'(disp_bank), 0);
    vblank = 1'b1;
    taddr  = AW'(5);
    expQ.push_back(expBank[5]);
    tick();
    check("defer_done", 32'(done), 1);
    check("defer_disp_new", 32'(disp_bank), 1);
    check("defer_swap_read", 32'(tvalue), expQ.pop_front());
    for (int i = 0; i < DEPTH; i++) expBank[i] = rowOf(64 + i);
    readAt("defer_new_read", 5, expBank[5]);
    check("defer_done_pulse", 32'(done), 0);
    sweep("defer_bank");

    // No trigger on a flat signal below threshold, then force
    trig_level = 8'd200; sample = 8'd10; sample_valid = 1'b1;
    arm = 1'b1; tick(); arm = 1'b0;
    cnt = 0;
    for (int n = 0; n < 10000; n++) begin
      tick();
      if (done) cnt++;
    end
    check("notrig_done", 32'(cnt), 0);
    check("notrig_busy", 32'(busy), 1);
    forceTrig = 1'b1; tick(); forceTrig = 1'b0;
    doneAt = -1;
    for (int n = 1; n <= 1000; n++) begin
      tick();
      if (done) begin
        doneAt = n;
        break;
      end
    end
    sample_valid = 1'b0;
    check("force_done_lat", 32'(doneAt), DEPTH);
    check("force_disp", 32'(disp_bank), 0);
    tick();
    for (int i = 0; i < DEPTH; i++) expBank[i] = 461;
    sweep("force_bank");

    // Auto re-arm on a periodic ramp: done pulses alternate banks
    trig_level = 8'd128; decim = 4'd0; vblank = 1'b1; auto_rearm = 1'b1;
    doneKQ.push_back(768);  doneBankQ.push_back(1);
    doneKQ.push_back(1536); doneBankQ.push_back(0);
    doneKQ.push_back(2304); doneBankQ.push_back(1);
    arm = 1'b1; tick(); arm = 1'b0;
    streamK = 0;
    for (int n = 0; n < 3000 && doneKQ.size() > 0; n++) begin
      sample = 8'(streamK % 256); sample_valid = 1'b1;
      tick();
      if (done) begin
        check("rearm_done_k", 32'(streamK), doneKQ.pop_front());
        check("rearm_disp", 32'(disp_bank), doneBankQ.pop_front());
      end
      streamK++;
    end
    sample_valid = 1'b0; auto_rearm = 1'b0;
    check("rearm_all_done", 32'(doneKQ.size()), 0);
    readAt("rearm_x639", 639, rowOf(128 + 639));
    readAt("rearm_x700", 700, rowOf(128 + 639));
    readAt("rearm_x1023", 1023, 1);
    readAt("rearm_x0", 0, 239);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
